// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, default latencies, result width and FSM states for the multiply/divide unit.
package mdu_pkg;
    localparam int RES_W           = 64;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MTHI  = 4'd4;
    localparam logic [3:0] MDU_MTLO  = 4'd5;
    localparam logic [3:0] MDU_MADD  = 4'd6;
    localparam logic [3:0] MDU_MADDU = 4'd7;
    localparam logic [3:0] MDU_MSUB  = 4'd8;
    localparam logic [3:0] MDU_MSUBU = 4'd9;
    typedef enum logic {MDU_IDLE, MDU_RUN} mdu_state_t;
    function automatic logic is_div(input logic [3:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction
    function automatic logic is_acc(input logic [3:0] op);
        return op >= MDU_MADD && op <= MDU_MSUBU;
    endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational product, quotient/remainder and (with MDU_MADD_EN) HI/LO accumulate.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]       Op,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
`ifdef MDU_MADD_EN
    input  logic [31:0]      HI,
    input  logic [31:0]      LO,
`endif
    output logic [RES_W-1:0] Res,
    output logic             DivZero
);
    logic             sgn, a_neg, b_neg;
    logic [31:0]      a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [RES_W-1:0] prod;
    // Signed ops divide magnitudes and fix signs after, so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        sgn     = Op == MDU_MULT || Op == MDU_DIV || Op == MDU_MADD || Op == MDU_MSUB;
        a_neg   = sgn & A[31];
        b_neg   = sgn & B[31];
        prod    = {{32{a_neg}}, A} * {{32{b_neg}}, B};
        a_mag   = a_neg ? -A : A;
        b_mag   = b_neg ? -B : B;
        q_mag   = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag   = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
        DivZero = is_div(Op) && B == 32'd0;
    end
`ifdef MDU_MADD_EN
    assign Res = is_div(Op) ? {rem, quot} :
                 (Op == MDU_MADD || Op == MDU_MADDU) ? {HI, LO} + prod :
                 (Op == MDU_MSUB || Op == MDU_MSUBU) ? {HI, LO} - prod : prod;
`else
    assign Res = is_div(Op) ? {rem, quot} : prod;
`endif
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MDU with Start/Busy handshake owning HI/LO; MDU_MADD_EN enables ops 6-9.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    mdu_state_t       state_q;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_load;
    logic [RES_W-1:0] pend_q, res;
    logic             dz_q, busy_q, div_zero, legal;
    logic [31:0]      hi_q, lo_q;
    mdu_arith u_arith (
        .Op      (Op),
        .A       (A),
        .B       (B),
`ifdef MDU_MADD_EN
        .HI      (hi_q),
        .LO      (lo_q),
`endif
        .Res     (res),
        .DivZero (div_zero)
    );
`ifdef MDU_MADD_EN
    assign legal = Op <= MDU_DIVU || is_acc(Op);
`else
    assign legal = Op <= MDU_DIVU;
`endif
    assign cnt_load = is_div(Op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    assign cnt_d    = cnt_q - CW'(1);
    assign Busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    // Start is only honoured in IDLE; a divide-by-zero runs full length but skips the commit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (state_q == MDU_IDLE) begin
            if (Start && Op == MDU_MTHI) hi_q <= A;
            else if (Start && Op == MDU_MTLO) lo_q <= A;
            else if (Start && legal) begin
                pend_q  <= res;
                dz_q    <= div_zero;
                cnt_q   <= cnt_load;
                busy_q  <= 1'b1;
                state_q <= MDU_RUN;
            end
        end else begin
            cnt_q <= cnt_d;
            if (cnt_q == CW'(1)) begin
                if (!dz_q) {hi_q, lo_q} <= pend_q;
                busy_q  <= 1'b0;
                state_q <= MDU_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0, b = 32'd0, hi, lo, hi_m = 32'd0, lo_m = 32'd0;
    logic        busy;
    int          vectors = 0, errors = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
        .Busy(busy), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [63:0] acc, output int n, output logic [63:0] r);
        longint sx, sy, q, rm;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = acc;
        n  = 0;
        case (o)
            4'd0: begin n = MC; r = sx * sy; end
            4'd1: begin n = MC; r = ux * uy; end
            4'd2: begin
                n = DC;
                if (y != 0) begin q = sx / sy; rm = sx % sy; r = {rm[31:0], q[31:0]}; end
            end
            4'd3: begin n = DC; if (y != 0) r = {x % y, x / y}; end
            4'd4: r = {x, acc[31:0]};
            4'd5: r = {acc[63:32], x};
`ifdef MDU_MADD_EN
            4'd6: begin n = MC; r = acc + sx * sy; end
            4'd7: begin n = MC; r = acc + ux * uy; end
            4'd8: begin n = MC; r = acc - sx * sy; end
            4'd9: begin n = MC; r = acc - ux * uy; end
`endif
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int n, busy_n;
        logic [63:0] old, exp;
        old = {hi_m, lo_m};
        model(o, x, y, old, n, exp);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        busy_n = 0;
        for (int i = 0; i < n + 2; i++) begin
            if (busy) busy_n++;
            if (i == n - 1) chk($sformatf("hold op%0d", o), {hi, lo}, old);
            tick();
        end
        chk($sformatf("busy_len op%0d", o), 64'(busy_n), 64'(n));
        chk($sformatf("hilo op%0d a=%h b=%h", o, x, y), {hi, lo}, exp);
        {hi_m, lo_m} = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        #9 rst = 1'b0;
        tick();
        chk("post_reset_hilo", {hi, lo}, 64'd0);

        run_op(4'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(4'd2, -32'sd7, 32'd2);
        chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(4'd4, 32'h11, 32'd0);
        run_op(4'd5, 32'h22, 32'd0);
        run_op(4'd3, 32'd100, 32'd0);
        chk("divu_zero_const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op(4'd12, 32'h1234, 32'h5678);
`ifdef MDU_MADD_EN
        run_op(4'd4, 32'd0, 32'd0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd7, 32'd1, 32'd1);
        chk("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        run_op(4'd7, 32'd1, 32'd1);
        chk("maddu_off_const", {hi, lo}, 64'h0000_0011_0000_0022);
`endif

        // DIV in flight, MULT Start on the third busy cycle must be ignored
        begin
            int n;
            logic [63:0] exp;
            model(4'd2, 32'd1000, 32'd7, {hi_m, lo_m}, n, exp);
            start = 1'b1; op = 4'd2; a = 32'd1000; b = 32'd7;
            tick();
            start = 1'b0;
            tick(); tick();
            start = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
            tick();
            start = 1'b0;
            for (int i = 0; i < 6; i++) tick();
            chk("overlap_busy_t10", {63'd0, busy}, 64'd1);
            chk("overlap_hold_t10", {hi, lo}, {hi_m, lo_m});
            tick();
            chk("overlap_busy_t11", {63'd0, busy}, 64'd0);
            chk("overlap_hilo_t11", {hi, lo}, exp);
            for (int i = 0; i < 6; i++) tick();
            chk("overlap_no_restart", {63'd0, busy}, 64'd0);
            chk("overlap_hilo_late", {hi, lo}, exp);
            {hi_m, lo_m} = exp;
        end

        for (int k = 0; k < 60; k++) run_op(4'($urandom_range(0, 15)), pick(), pick());

        // Reset mid-MULT aborts with no commit
        run_op(4'd4, 32'hDEAD_BEEF, 32'd0);
        start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        #2 rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_commit", {hi, lo}, 64'd0);
        chk("abort_idle", {63'd0, busy}, 64'd0);
        run_op(4'd1, 32'd7, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
